axi_tagctrl_way_rd_issuer: RTL and testbench
============================================

# axi_tagctrl_way_rd_issuer

Requester-side engine for the tag controller's data-way port. It accepts a line-read descriptor and issues one way read request per beat, with a wrapping block offset. The requests go into one unit slot of the way crossbar. It then collects the in-order read responses, buffers them under credit control, and forwards them downstream with a `last` marker per descriptor. It is the initiator counterpart of the data-way interconnect, used by read-type units (read channel, evict).

## Interface
Parameters:
- `SetAssociativity`, 8: number of ways; width of the one-hot way indicator.
- `LineAddrWidth`, 10: width of the line (set) address.
- `BeatsPerLine`, 8: data beats per cache line; power of two, ≥2.
- `MaxOutstanding`, 4: credits, i.e. maximum issued-but-not-forwarded beats; ≥1.
- `DataWidth`, 64: width of the response data.
- `UnitId`, 2'd3: unit code driven on requests and expected on responses.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `desc_valid_i`  in  1  descriptor valid.
- `desc_ready_o`  out  1  descriptor accepted.
- `desc_way_ind_i`  in  SetAssociativity  one-hot target way.
- `desc_line_i`  in  LineAddrWidth  line address.
- `desc_offset_i`  in  $clog2(BeatsPerLine)  first beat offset.
- `desc_beats_i`  in  $clog2(BeatsPerLine+1)  beat count, 1..BeatsPerLine.
- `req_valid_o` / `req_ready_i`  out/in  1  way request handshake (AXI valid/ready).
- `req_way_ind_o`  out  SetAssociativity  one-hot way.
- `req_line_o`  out  LineAddrWidth  line address.
- `req_offset_o`  out  $clog2(BeatsPerLine)  beat offset.
- `req_unit_o`  out  2  constant `UnitId`.
- `resp_valid_i` / `resp_ready_o`  in/out  1  way response handshake.
- `resp_data_i`  in  DataWidth  response data.
- `resp_unit_i`  in  2  response unit code.
- `out_valid_o` / `out_ready_i`  out/in  1  downstream beat handshake.
- `out_data_o`  out  DataWidth  beat data.
- `out_last_o`  out  1  final beat of a descriptor.
- `busy_o`  out  1  state ≠ IDLE, or any credit in use.
- `err_o`  out  1  sticky: a response arrived with `resp_unit_i` ≠ `UnitId`.

## Operation
- FSM states:
  - IDLE: `desc_ready_o`=1. A descriptor handshake latches way, line, offset and beats, then moves to ISSUE.
  - ISSUE: `req_valid_o` = (credits_used < MaxOutstanding). Each request handshake does the following:
    - offset ← (offset+1) mod BeatsPerLine (wraps);
    - remaining−1;
    - pushes the tag bit (remaining==1) into the last-tag FIFO.
  - When the handshake with remaining==1 completes, return to IDLE.
- Request payload is stable while `req_valid_o`=1. Valid is never withdrawn once raised unless the module is reset.
- Credits: `credits_used` counts beats from request handshake until output handshake. A request handshake adds 1 and an output handshake subtracts 1; both in the same cycle leave it unchanged. Width is $clog2(MaxOutstanding+1).
- Response FIFO: depth MaxOutstanding, stores {data, last}. `last` comes from the head of the last-tag FIFO (also depth MaxOutstanding), popped on each response handshake.
  - Credits guarantee no overflow, so `resp_ready_o`=1 out of reset.
  - A response while the tag FIFO is empty is a protocol error; the simulation assertion fires.
- Output: `out_valid_o` = response FIFO not empty. The FIFO pops on `out_valid_o & out_ready_i`.
- Back-to-back descriptors: a new descriptor is accepted in IDLE while earlier beats are still outstanding. Ordering is preserved because the way interconnect returns responses in issue order.
- `desc_beats_i`=0 is illegal (assertion). Way indicator not one-hot is illegal (assertion).
- `err_o` is set on any response handshake with a mismatching unit code and cleared only by reset. The data is still forwarded.

## Timing
- Reset values (also while `rst_i`=1):
  - state IDLE; `desc_ready_o`=1 after release (0 while `rst_i`=1);
  - `req_valid_o`=0, `out_valid_o`=0, `out_last_o`=0, `busy_o`=0, `err_o`=0;
  - credits 0, FIFOs empty, `resp_ready_o`=0 while in reset, 1 after.
- Descriptor handshake in cycle N: `req_valid_o`=1 in N+1, provided a credit is free. No combinational path from `desc_valid_i` to `req_valid_o`.
- Issue throughput is 1 request/cycle while credits are available and `req_ready_i`=1.
- Response handshake in cycle N: `out_valid_o`=1 in N+1 (non-fall-through). No combinational path from `resp_*` to `out_*`.
- Output handshake in cycle N frees a credit, and a stalled `req_valid_o` may rise in N+1.
- Reset mid-burst: all state, credits and FIFOs are cleared immediately. Responses arriving after release are dropped (`resp_ready_o`=1) and flagged by assertion only.

## Test plan
- Single read: way_ind=8'b0000_0100, line=0x05, offset=0, beats=4, sinks always ready. Required response:
  - 4 requests with offsets 0,1,2,3;
  - 4 output beats in order, `out_last_o`=1 only on the 4th;
  - `busy_o` returns to 0.
- Wrap: offset=6, beats=4, BeatsPerLine=8 → requested offsets 6,7,0,1.
- Credit stall: MaxOutstanding=4, beats=8, `out_ready_i`=0.
  - Exactly 4 requests are issued, then `req_valid_o`=0.
  - Raising `out_ready_i` for one cycle lets exactly one more request issue in the next cycle.
- Back-to-back: two descriptors (beats=2, then beats=3) with responses delayed 3 cycles → 5 output beats in order, `out_last_o` on beats 2 and 5.
- Backpressure/unit error: random `req_ready_i`/`out_ready_i` over 200 descriptors with data intact and no overflow. Then one response with `resp_unit_i`=0 → `err_o`=1 from the next cycle and stays 1.
- Reset mid-operation: assert `rst_i` during beat 3 of 8 → the next cycle shows `req_valid_o`=0, `out_valid_o`=0 and credits 0. After release, a fresh beats=2 descriptor completes normally.

Source files
------------

// File: rtl/axi_tagctrl_way_rd_issuer.sv
// Way-port read issuer: turns line-read descriptors into per-beat way requests with
// wrapping offsets, then buffers in-order responses under credits and tags the final beat.

module axi_tagctrl_way_rd_issuer_chk #(
  parameter int SetAssociativity = 8,
  parameter int BeatW            = 4
) (
  input logic                        clk,
  input logic                        rst,
  input logic                        desc_fire,
  input logic [SetAssociativity-1:0] desc_way_ind,
  input logic [BeatW-1:0]            desc_beats,
  input logic                        resp_fire,
  input logic                        tag_empty
);

  a_desc_beats_nonzero: assert property (@(posedge clk) disable iff (rst)
    desc_fire |-> (desc_beats != {BeatW{1'b0}}));

  a_desc_way_onehot: assert property (@(posedge clk) disable iff (rst)
    desc_fire |-> $onehot(desc_way_ind));

  // A response with no matching issued beat is a stale or spurious return.
  a_resp_has_tag: assert property (@(posedge clk) disable iff (rst)
    resp_fire |-> !tag_empty);

endmodule

module axi_tagctrl_way_rd_issuer #(
  parameter int         SetAssociativity = 8,
  parameter int         LineAddrWidth    = 10,
  parameter int         BeatsPerLine     = 8,
  parameter int         MaxOutstanding   = 4,
  parameter int         DataWidth        = 64,
  parameter logic [1:0] UnitId           = 2'd3
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               desc_valid_i,
  output logic                               desc_ready_o,
  input  logic [SetAssociativity-1:0]        desc_way_ind_i,
  input  logic [LineAddrWidth-1:0]           desc_line_i,
  input  logic [$clog2(BeatsPerLine)-1:0]    desc_offset_i,
  input  logic [$clog2(BeatsPerLine+1)-1:0]  desc_beats_i,
  output logic                               req_valid_o,
  input  logic                               req_ready_i,
  output logic [SetAssociativity-1:0]        req_way_ind_o,
  output logic [LineAddrWidth-1:0]           req_line_o,
  output logic [$clog2(BeatsPerLine)-1:0]    req_offset_o,
  output logic [1:0]                         req_unit_o,
  input  logic                               resp_valid_i,
  output logic                               resp_ready_o,
  input  logic [DataWidth-1:0]               resp_data_i,
  input  logic [1:0]                         resp_unit_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [DataWidth-1:0]               out_data_o,
  output logic                               out_last_o,
  output logic                               busy_o,
  output logic                               err_o
);

  localparam int OffW  = $clog2(BeatsPerLine);
  localparam int BeatW = $clog2(BeatsPerLine + 1);
  localparam int CredW = $clog2(MaxOutstanding + 1);
  localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  localparam logic [CredW-1:0] CRED_MAX  = CredW'(MaxOutstanding);
  localparam logic [CredW-1:0] CRED_ZERO = {CredW{1'b0}};
  localparam logic [PtrW-1:0]  PTR_LAST  = PtrW'(MaxOutstanding - 1);
  localparam logic [PtrW-1:0]  PTR_ZERO  = {PtrW{1'b0}};
  localparam logic [BeatW-1:0] BEAT_ONE  = BeatW'(1);

  // FIFO depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PTR_LAST) begin
      ptr_inc = PTR_ZERO;
    end else begin
      ptr_inc = ptr + PtrW'(1);
    end
  endfunction

  logic                        active_r;
  logic                        desc_ready_r;
  logic                        req_valid_r;
  logic                        busy_r;
  logic                        err_r;
  logic [0:0]                  state_r;
  logic [0:0]                  state_nxt_s;
  logic [CredW-1:0]            credits_r;
  logic [CredW-1:0]            credits_nxt_s;
  logic [SetAssociativity-1:0] way_r;
  logic [LineAddrWidth-1:0]    line_r;
  logic [OffW-1:0]             offset_r;
  logic [BeatW-1:0]            remaining_r;

  logic                        tag_mem_r [MaxOutstanding];
  logic [PtrW-1:0]             tag_wr_r;
  logic [PtrW-1:0]             tag_rd_r;
  logic [CredW-1:0]            tag_cnt_r;

  logic [DataWidth-1:0]        rf_data_r [MaxOutstanding];
  logic                        rf_last_r [MaxOutstanding];
  logic [PtrW-1:0]             rf_wr_r;
  logic [PtrW-1:0]             rf_rd_r;
  logic [CredW-1:0]            rf_cnt_r;

  logic desc_fire_s;
  logic req_fire_s;
  logic resp_fire_s;
  logic resp_push_s;
  logic out_fire_s;
  logic tag_empty_s;
  logic last_beat_s;

  assign desc_ready_o  = desc_ready_r;
  assign req_valid_o   = req_valid_r;
  assign req_way_ind_o = way_r;
  assign req_line_o    = line_r;
  assign req_offset_o  = offset_r;
  assign req_unit_o    = UnitId;
  assign resp_ready_o  = active_r;
  assign busy_o        = busy_r;
  assign err_o         = err_r;
  assign out_valid_o   = (rf_cnt_r != CRED_ZERO);
  assign out_data_o    = rf_data_r[rf_rd_r];
  assign out_last_o    = out_valid_o & rf_last_r[rf_rd_r];

  assign desc_fire_s = desc_valid_i & desc_ready_r;
  assign req_fire_s  = req_valid_r & req_ready_i;
  assign resp_fire_s = resp_valid_i & active_r;
  assign out_fire_s  = out_valid_o & out_ready_i;
  assign tag_empty_s = (tag_cnt_r == CRED_ZERO);
  // Responses with no outstanding tag (e.g. stale after reset) are dropped.
  assign resp_push_s = resp_fire_s & ~tag_empty_s;
  assign last_beat_s = (remaining_r == BEAT_ONE);

  // Next state and next credit count.
  always_comb begin
    state_nxt_s   = state_r;
    credits_nxt_s = credits_r;
    case (state_r)
      ST_IDLE: begin
        if (desc_fire_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (req_fire_s && last_beat_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (req_fire_s && !out_fire_s) begin
      credits_nxt_s = credits_r + CredW'(1);
    end else if (!req_fire_s && out_fire_s) begin
      credits_nxt_s = credits_r - CredW'(1);
    end else begin
      credits_nxt_s = credits_r;
    end
  end

  // Control registers; handshake outputs are registered from the next-state values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_r     <= 1'b0;
      state_r      <= ST_IDLE;
      credits_r    <= CRED_ZERO;
      desc_ready_r <= 1'b0;
      req_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      active_r     <= 1'b1;
      state_r      <= state_nxt_s;
      credits_r    <= credits_nxt_s;
      desc_ready_r <= (state_nxt_s == ST_IDLE);
      req_valid_r  <= (state_nxt_s == ST_ISSUE) && (credits_nxt_s < CRED_MAX);
      busy_r       <= (state_nxt_s != ST_IDLE) || (credits_nxt_s != CRED_ZERO);
      if (resp_fire_s && (resp_unit_i != UnitId)) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Descriptor latch and per-beat offset/remaining walk.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      way_r       <= {SetAssociativity{1'b0}};
      line_r      <= {LineAddrWidth{1'b0}};
      offset_r    <= {OffW{1'b0}};
      remaining_r <= {BeatW{1'b0}};
    end else if (desc_fire_s) begin
      way_r       <= desc_way_ind_i;
      line_r      <= desc_line_i;
      offset_r    <= desc_offset_i;
      remaining_r <= desc_beats_i;
    end else if (req_fire_s) begin
      offset_r    <= offset_r + OffW'(1);
      remaining_r <= remaining_r - BEAT_ONE;
    end else begin
      offset_r    <= offset_r;
      remaining_r <= remaining_r;
    end
  end

  // Last-tag FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_wr_r  <= PTR_ZERO;
      tag_rd_r  <= PTR_ZERO;
      tag_cnt_r <= CRED_ZERO;
    end else begin
      if (req_fire_s) begin
        tag_wr_r <= ptr_inc(tag_wr_r);
      end
      if (resp_push_s) begin
        tag_rd_r <= ptr_inc(tag_rd_r);
      end
      case ({req_fire_s, resp_push_s})
        2'b10:   tag_cnt_r <= tag_cnt_r + CredW'(1);
        2'b01:   tag_cnt_r <= tag_cnt_r - CredW'(1);
        default: tag_cnt_r <= tag_cnt_r;
      endcase
    end
  end

  // Last-tag storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_i) begin
    if (req_fire_s) begin
      tag_mem_r[tag_wr_r] <= last_beat_s;
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_wr_r  <= PTR_ZERO;
      rf_rd_r  <= PTR_ZERO;
      rf_cnt_r <= CRED_ZERO;
    end else begin
      if (resp_push_s) begin
        rf_wr_r <= ptr_inc(rf_wr_r);
      end
      if (out_fire_s) begin
        rf_rd_r <= ptr_inc(rf_rd_r);
      end
      case ({resp_push_s, out_fire_s})
        2'b10:   rf_cnt_r <= rf_cnt_r + CredW'(1);
        2'b01:   rf_cnt_r <= rf_cnt_r - CredW'(1);
        default: rf_cnt_r <= rf_cnt_r;
      endcase
    end
  end

  // Response storage: data with the last marker taken from the tag FIFO head.
  always_ff @(posedge clk_i) begin
    if (resp_push_s) begin
      rf_data_r[rf_wr_r] <= resp_data_i;
      rf_last_r[rf_wr_r] <= tag_mem_r[tag_rd_r];
    end
  end

  axi_tagctrl_way_rd_issuer_chk #(
    .SetAssociativity(SetAssociativity),
    .BeatW           (BeatW)
  ) u_chk (
    .clk          (clk_i),
    .rst          (rst_i),
    .desc_fire    (desc_fire_s),
    .desc_way_ind (desc_way_ind_i),
    .desc_beats   (desc_beats_i),
    .resp_fire    (resp_fire_s),
    .tag_empty    (tag_empty_s)
  );

endmodule

// File: tb/tb_axi_tagctrl_way_rd_issuer.sv
// Scoreboard bench for axi_tagctrl_way_rd_issuer: expected requests and beats come from
// descriptor arithmetic; monitors pop and compare whenever the DUT handshakes.

module tb_axi_tagctrl_way_rd_issuer;

  localparam logic [1:0] UNIT = 2'd3;

  typedef struct {
    logic [7:0] way;
    logic [9:0] line;
    logic [2:0] off;
    logic       last;
  } req_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  unit;
    logic        last;
    int          t;
  } pend_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [7:0]  desc_way = 8'd0;
  logic [9:0]  desc_line = 10'd0;
  logic [2:0]  desc_off = 3'd0;
  logic [3:0]  desc_beats = 4'd0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [7:0]  req_way;
  logic [9:0]  req_line;
  logic [2:0]  req_off;
  logic [1:0]  req_unit;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [63:0] resp_data = 64'd0;
  logic [1:0]  resp_unit = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic        err;

  req_t  req_exp[$];
  pend_t pend[$];
  out_t  out_exp[$];
  logic  out_lasts[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int issued = 0;
  int outs = 0;
  int req_mode = 0;
  int out_mode = 1;
  int out_pulse = 0;
  int dmin = 1;
  int dmax = 1;
  logic bad_next = 1'b0;
  logic bad_seen = 1'b0;

  axi_tagctrl_way_rd_issuer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .desc_valid_i   (desc_valid),
    .desc_ready_o   (desc_ready),
    .desc_way_ind_i (desc_way),
    .desc_line_i    (desc_line),
    .desc_offset_i  (desc_off),
    .desc_beats_i   (desc_beats),
    .req_valid_o    (req_valid),
    .req_ready_i    (req_ready),
    .req_way_ind_o  (req_way),
    .req_line_o     (req_line),
    .req_offset_o   (req_off),
    .req_unit_o     (req_unit),
    .resp_valid_i   (resp_valid),
    .resp_ready_o   (resp_ready),
    .resp_data_i    (resp_data),
    .resp_unit_i    (resp_unit),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .out_last_o     (out_last),
    .busy_o         (busy),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Request-side sink readiness.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (req_mode == 0) req_ready = 1'b1;
      else req_ready = ($urandom_range(1, 0) == 1);
    end
  end

  // Output-side sink readiness, with single-cycle pulse support.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (out_pulse > 0) begin
        out_ready = 1'b1;
        out_pulse--;
      end else if (out_mode == 0) out_ready = 1'b0;
      else if (out_mode == 1) out_ready = 1'b1;
      else out_ready = ($urandom_range(3, 0) != 0);
    end
  end

  // Request monitor: checks payload and schedules the in-order response.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && req_valid && req_ready) begin
        req_t  r;
        pend_t p;
        int    d;
        issued++;
        if (req_exp.size() == 0) begin
          chk("req_unexpected", 64'(1), 64'(0));
        end else begin
          r = req_exp.pop_front();
          chk("req_way", 64'(req_way), 64'(r.way));
          chk("req_line", 64'(req_line), 64'(r.line));
          chk("req_offset", 64'(req_off), 64'(r.off));
          chk("req_unit", 64'(req_unit), 64'(UNIT));
          d = (dmin == dmax) ? dmin : int'($urandom_range(dmax, dmin));
          p.data = {$urandom, $urandom};
          p.unit = bad_next ? 2'd0 : UNIT;
          bad_next = 1'b0;
          p.last = r.last;
          p.t = cycle + d;
          pend.push_back(p);
        end
      end
    end
  end

  // Responder: drives scheduled responses; a completed one becomes an expected output.
  initial begin
    pend_t cur;
    logic  hs;
    cur.data = 64'd0;
    cur.unit = 2'd0;
    cur.last = 1'b0;
    cur.t = 0;
    forever begin
      @(negedge clk);
      hs = resp_valid && resp_ready;
      @(posedge clk);
      #1;
      if (rst) begin
        resp_valid = 1'b0;
        hs = 1'b0;
      end
      if (hs) begin
        out_t o;
        o.data = cur.data;
        o.last = cur.last;
        out_exp.push_back(o);
        if (cur.unit != UNIT) bad_seen = 1'b1;
        resp_valid = 1'b0;
      end
      if (!resp_valid && !rst && pend.size() > 0 && pend[0].t <= cycle) begin
        cur = pend.pop_front();
        resp_valid = 1'b1;
        resp_data = cur.data;
        resp_unit = cur.unit;
      end
    end
  end

  // Output monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        out_t o;
        outs++;
        out_lasts.push_back(out_last);
        if (out_exp.size() == 0) begin
          chk("out_unexpected", 64'(1), 64'(0));
        end else begin
          o = out_exp.pop_front();
          chk("out_data", out_data, o.data);
          chk("out_last", 64'(out_last), 64'(o.last));
        end
      end
    end
  end

  task automatic send_desc(input logic [7:0] way, input logic [9:0] line,
                           input logic [2:0] off, input int beats);
    int n = 0;
    @(negedge clk);
    while (desc_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk("desc_accept_timeout", 64'(n), 64'(0));
    end else begin
      for (int i = 0; i < beats; i++) begin
        req_t r;
        r.way = way;
        r.line = line;
        r.off = 3'((int'(off) + i) % 8);
        r.last = (i == beats - 1);
        req_exp.push_back(r);
      end
      @(posedge clk);
      #1;
      desc_valid = 1'b1;
      desc_way = way;
      desc_line = line;
      desc_off = off;
      desc_beats = 4'(beats);
      @(posedge clk);
      #1;
      desc_valid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    @(negedge clk);
    while (!(busy == 1'b0 && req_exp.size() == 0 && pend.size() == 0 &&
             out_exp.size() == 0 && resp_valid == 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n >= budget), 64'(0));
    chk("busy_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    int base;
    int n;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_desc_ready", 64'(desc_ready), 64'(0));
    chk("rst_req_valid", 64'(req_valid), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_resp_ready", 64'(resp_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_desc_ready", 64'(desc_ready), 64'(1));
    chk("post_rst_resp_ready", 64'(resp_ready), 64'(1));

    // Single read
    base = issued;
    send_desc(8'b0000_0100, 10'h005, 3'd0, 4);
    drain(500);
    chk("single_req_count", 64'(issued - base), 64'(4));

    // Wrapping offset
    base = issued;
    send_desc(8'b0000_0001, 10'h0A7, 3'd6, 4);
    drain(500);
    chk("wrap_req_count", 64'(issued - base), 64'(4));

    // Credit stall
    out_mode = 0;
    base = issued;
    send_desc(8'b0010_0000, 10'h123, 3'd0, 8);
    repeat (20) @(negedge clk);
    chk("stall_issued", 64'(issued - base), 64'(4));
    chk("stall_req_valid", 64'(req_valid), 64'(0));
    out_pulse = 1;
    repeat (10) @(negedge clk);
    chk("stall_one_more", 64'(issued - base), 64'(5));
    chk("stall_req_valid_again", 64'(req_valid), 64'(0));
    out_mode = 1;
    drain(500);
    chk("stall_req_total", 64'(issued - base), 64'(8));

    // Back-to-back descriptors, responses delayed 3 cycles
    dmin = 3;
    dmax = 3;
    base = outs;
    out_lasts.delete();
    send_desc(8'b0001_0000, 10'h03A, 3'd2, 2);
    send_desc(8'b1000_0000, 10'h111, 3'd7, 3);
    drain(500);
    chk("b2b_out_count", 64'(outs - base), 64'(5));
    if (out_lasts.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("b2b_last_pos", 64'(out_lasts[i]), 64'((i == 1) || (i == 4)));
      end
    end else begin
      chk("b2b_last_log", 64'(out_lasts.size()), 64'(5));
    end

    // Random backpressure
    req_mode = 1;
    out_mode = 2;
    dmin = 0;
    dmax = 3;
    base = issued;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      int b = int'($urandom_range(8, 1));
      n += b;
      send_desc(8'(1 << $urandom_range(7, 0)), 10'($urandom), 3'($urandom_range(7, 0)), b);
    end
    drain(20000);
    chk("rand_req_total", 64'(issued - base), 64'(n));
    chk("rand_err_clear", 64'(err), 64'(0));

    // Unit-code error
    req_mode = 0;
    out_mode = 1;
    dmin = 1;
    dmax = 1;
    bad_seen = 1'b0;
    bad_next = 1'b1;
    send_desc(8'b0100_0000, 10'h2F0, 3'd5, 1);
    n = 0;
    while (!bad_seen && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("unit_err_resp_timeout", 64'(n >= 200), 64'(0));
    @(negedge clk);
    chk("unit_err_set", 64'(err), 64'(1));
    repeat (5) @(negedge clk);
    chk("unit_err_sticky", 64'(err), 64'(1));
    drain(500);
    chk("unit_err_still", 64'(err), 64'(1));

    // Reset during beat 3 of 8
    dmin = 30;
    dmax = 30;
    base = issued;
    send_desc(8'b0000_1000, 10'h1C4, 3'd1, 8);
    n = 0;
    while (issued < base + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reach_beat3", 64'(n >= 200), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_exp.delete();
    pend.delete();
    out_exp.delete();
    @(negedge clk);
    chk("rst_mid_req_valid", 64'(req_valid), 64'(0));
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_err", 64'(err), 64'(0));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dmin = 1;
    dmax = 1;
    base = outs;
    send_desc(8'b0000_0010, 10'h2C0, 3'd7, 2);
    drain(500);
    chk("rst_mid_fresh_outs", 64'(outs - base), 64'(2));
    chk("rst_mid_desc_ready", 64'(desc_ready), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
